// File: rtl/spi_slave_if.sv
// SPI pins plus byte-wide TX/RX handshake between the SPI peripheral and local logic.
interface spi_slave_if;
  logic       r_spi_clk;
  logic       r_cs_n;
  logic       r_mosi;
  logic       w_miso;
  logic [7:0] r_data;
  logic       r_data_ready;
  logic       w_data_ready;
  logic [7:0] w_data;
  logic       w_slave_done;

  modport slave (
    input  r_spi_clk, r_cs_n, r_mosi, r_data, r_data_ready,
    output w_miso, w_data_ready, w_data, w_slave_done
  );

  modport master (
    output r_spi_clk, r_cs_n, r_mosi, r_data, r_data_ready,
    input  w_miso, w_data_ready, w_data, w_slave_done
  );
endinterface

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples SCLK/CS_N/MOSI in r_clk, assembles RX bytes
// MSB-first and serialises a one-byte TX holding register onto MISO.
module spi_slave #(
  parameter int unsigned SPI_MODE = 3
) (
  input logic        r_clk,
  input logic        r_reset,
  spi_slave_if.slave bus
);

  localparam logic [1:0] MODE = 2'(SPI_MODE);
  localparam logic       CPOL = MODE[1];
  localparam logic       CPHA = MODE[0];

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e     state_q;
  logic [2:0] sclk_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;
  logic [2:0] cnt_q;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] data_q;
  logic       done_q;
  logic       miso_q;

  logic       lead_d;
  logic       trail_d;
  logic       sample_d;
  logic       shift_d;
  logic       cs_fall_d;
  logic       cs_rise_d;
  logic [7:0] rx_byte_d;
  logic [7:0] reload_d;
  logic [7:0] tx_load_d;

  always_ff @(posedge r_clk) begin
    if (!r_reset) begin
      sclk_q <= {3{CPOL}};
      csn_q  <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.r_spi_clk};
      csn_q  <= {csn_q[1:0], bus.r_cs_n};
      mosi_q <= {mosi_q[0], bus.r_mosi};
    end
  end

  always_comb begin
    lead_d    = (sclk_q[2] == CPOL) && (sclk_q[1] != CPOL);
    trail_d   = (sclk_q[2] != CPOL) && (sclk_q[1] == CPOL);
    sample_d  = CPHA ? trail_d : lead_d;
    shift_d   = CPHA ? lead_d : trail_d;
    cs_fall_d = csn_q[2] & ~csn_q[1];
    cs_rise_d = ~csn_q[2] & csn_q[1];
    rx_byte_d = rx_q;
    rx_byte_d[cnt_q] = mosi_q[1];
    reload_d  = hold_full_q ? hold_q : '0;
    // CPHA=0 presents bit 7 at load time, so the shifter keeps only the bits still to go.
    tx_load_d = CPHA ? reload_d : {reload_d[6:0], 1'b0};
  end

  always_ff @(posedge r_clk) begin
    if (!r_reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd7;
      rx_q        <= '0;
      tx_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cs_fall_d) begin
            state_q     <= ACTIVE;
            cnt_q       <= 3'd7;
            tx_q        <= tx_load_d;
            hold_full_q <= 1'b0;
            if (!CPHA) miso_q <= reload_d[7];
          end
        end
        ACTIVE: begin
          if (cs_rise_d) begin
            state_q <= IDLE;
            cnt_q   <= 3'd7;
            miso_q  <= 1'b0;
          end else begin
            if (sample_d) begin
              rx_q  <= rx_byte_d;
              cnt_q <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                data_q      <= rx_byte_d;
                done_q      <= 1'b1;
                tx_q        <= tx_load_d;
                hold_full_q <= 1'b0;
                if (!CPHA) miso_q <= reload_d[7];
              end
            end
            // In CPHA=0 the trailing edge after the 8th sample would clobber the reloaded bit 7.
            if (shift_d && (CPHA || cnt_q != 3'd7)) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed after the FSM so a load coinciding with a reload still leaves the register full.
      if (bus.r_data_ready && !hold_full_q) begin
        hold_q      <= bus.r_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign bus.w_miso       = miso_q;
  assign bus.w_data       = data_q;
  assign bus.w_slave_done = done_q;
  assign bus.w_data_ready = ~hold_full_q;

endmodule

// File: tb/tb_spi_slave.sv
// Drives one SPI master pattern into all four SPI modes at once and checks RX bytes,
// MISO bytes and the TX handshake against a byte-level model of the holding register.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       b;
  logic       cs_n;
  logic       mosi0;
  logic       mosi1;
  logic [7:0] tdata;
  logic       tvalid;

  logic [3:0] miso_w;
  logic [3:0] done_w;
  logic [3:0] rdy_w;
  logic [7:0] data_w [4];

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rx [$];
  int         rx_cnt [4] = '{default: 0};
  logic       model_full = 1'b0;
  logic [7:0] model_val = '0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g
    localparam bit CPOL = (m >= 2);
    localparam bit CPHA = (m % 2 == 1);

    spi_slave_if bus ();

    assign bus.r_spi_clk    = b ^ CPOL;
    assign bus.r_cs_n       = cs_n;
    assign bus.r_mosi       = CPHA ? mosi1 : mosi0;
    assign bus.r_data       = tdata;
    assign bus.r_data_ready = tvalid;
    assign miso_w[m]        = bus.w_miso;
    assign done_w[m]        = bus.w_slave_done;
    assign rdy_w[m]         = bus.w_data_ready;
    assign data_w[m]        = bus.w_data;

    spi_slave #(.SPI_MODE(m)) dut (
      .r_clk   (clk),
      .r_reset (rst_n),
      .bus     (bus)
    );

    always @(negedge clk) begin
      if (done_w[m]) begin
        checks++;
        if (rx_cnt[m] >= exp_rx.size()) begin
          errors++;
          $display("FAIL rx_extra mode=%0d got=%02h required=no byte", m, data_w[m]);
        end else if (data_w[m] !== exp_rx[rx_cnt[m]]) begin
          errors++;
          $display("FAIL rx_byte mode=%0d idx=%0d got=%02h required=%02h",
                   m, rx_cnt[m], data_w[m], exp_rx[rx_cnt[m]]);
        end
        rx_cnt[m]++;
      end
    end
  end

  task automatic chk(input string name, input int mode, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s mode=%0d got=%02h required=%02h", name, mode, got, req);
    end
  endtask

  function automatic logic [7:0] consume();
    logic [7:0] r;
    r = model_full ? model_val : 8'h00;
    model_full = 1'b0;
    return r;
  endfunction

  task automatic chk_reset_outputs();
    for (int m = 0; m < 4; m++) begin
      chk("rst_miso", m, {7'd0, miso_w[m]}, 8'h00);
      chk("rst_data", m, data_w[m], 8'h00);
      chk("rst_done", m, {7'd0, done_w[m]}, 8'h00);
      chk("rst_ready", m, {7'd0, rdy_w[m]}, 8'h01);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    for (int m = 0; m < 4; m++) chk("tx_ready", m, {7'd0, rdy_w[m]}, {7'd0, ~model_full});
    tdata  = d;
    tvalid = 1'b1;
    if (!model_full) begin
      model_full = 1'b1;
      model_val  = d;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tdata  = 8'h5A;
  endtask

  // Each SCLK half period is 8 r_clk; leading edge is b rising for every mode.
  task automatic frame(input int nbits, input logic [23:0] mo, input logic [23:0] ld,
                       input logic [2:0] ld_en, input bit rst_abort);
    logic [7:0] cur_tx;
    logic [7:0] cap [4];
    int         k;
    int         j;
    logic       bitv;
    cap    = '{default: 8'h00};
    cur_tx = consume();
    cs_n   = 1'b0;
    b      = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      k    = i / 8;
      j    = 7 - (i % 8);
      bitv = mo[8*k+j];
      if (j == 7 && 8*k + 8 <= nbits && !rst_abort) exp_rx.push_back(mo[8*k +: 8]);
      mosi0 = bitv;
      repeat (7) @(negedge clk);
      cap[0][j] = miso_w[0];
      cap[2][j] = miso_w[2];
      @(negedge clk);
      b = 1'b1;
      repeat (3) @(negedge clk);
      mosi1 = bitv;
      if (j == 4 && ld_en[k]) do_load(ld[8*k +: 8]);
      else @(negedge clk);
      repeat (3) @(negedge clk);
      cap[1][j] = miso_w[1];
      cap[3][j] = miso_w[3];
      @(negedge clk);
      b = 1'b0;
      if (j == 0) begin
        for (int m = 0; m < 4; m++) chk("miso_byte", m, cap[m], cur_tx);
        cur_tx = consume();
      end
    end
    repeat (4) @(negedge clk);
    if (rst_abort) begin
      rst_n = 1'b0;
      cs_n  = 1'b1;
      @(negedge clk);
      chk_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n      = 1'b1;
      model_full = 1'b0;
    end else begin
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      for (int m = 0; m < 4; m++) chk("idle_miso", m, {7'd0, miso_w[m]}, 8'h00);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    int          nb;
    int          nbits;
    rst_n  = 1'b0;
    b      = 1'b0;
    cs_n   = 1'b1;
    mosi0  = 1'b0;
    mosi1  = 1'b0;
    tdata  = 8'h00;
    tvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_load(8'hA5);
    frame(8, 24'h00003C, 24'h0, 3'b000, 1'b0);

    do_load(8'h81);
    frame(16, 24'h00B2D4, 24'h00007E, 3'b001, 1'b0);

    frame(8, 24'h000096, 24'h0, 3'b000, 1'b0);

    frame(5, 24'h0000F0, 24'h0, 3'b000, 1'b0);
    frame(8, 24'h0000C3, 24'h0, 3'b000, 1'b0);

    do_load(8'h12);
    do_load(8'hFF);
    frame(8, 24'h000047, 24'h0, 3'b000, 1'b0);

    do_load(8'h6B);
    frame(3, 24'h0000E1, 24'h0, 3'b000, 1'b1);
    do_load(8'h39);
    frame(8, 24'h00005D, 24'h0, 3'b000, 1'b0);

    cs_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      b     = ~b;
      mosi0 = ~mosi0;
      mosi1 = ~mosi1;
      repeat (6) @(negedge clk);
    end
    for (int m = 0; m < 4; m++) chk("cs_high_miso", m, {7'd0, miso_w[m]}, 8'h00);

    for (int r = 0; r < 20; r++) begin
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) nbits = 8*(nb-1) + $urandom_range(1, 7);
      else nbits = 8*nb;
      if (r3[8]) do_load(r3[7:0]);
      frame(nbits, r1[23:0], r2[23:0], r3[2:0], 1'b0);
    end

    repeat (20) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (rx_cnt[m] != exp_rx.size()) begin
        errors++;
        $display("FAIL rx_count mode=%0d got=%0d required=%0d", m, rx_cnt[m], exp_rx.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
